// File: rtl/bin_to_bcd_serial_if.sv
// Request/result bundle of the serial binary-to-BCD converter.
// The requester drives start/bin_in; the converter answers with busy/done/bcd_out/overflow.
`timescale 1ns/1ps
interface bin_to_bcd_serial_if #(
    parameter int BIT_SIZE = 20,
    parameter int DIGITS   = 6
);
    // Handshake: start is a request that is only honoured while the converter is idle
    // (busy=0 and done=0); bin_in is captured on that accepted cycle. Requests made while
    // busy or during the done cycle are dropped, not queued. done is a one-cycle pulse and
    // bcd_out/overflow are valid from that cycle until the next done.
    logic                  start;
    logic [BIT_SIZE-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Iterative double-dabble converter: one shift per clock, saturating to all nines
// when the input does not fit in DIGITS decimal digits.
`timescale 1ns/1ps
module bin_to_bcd_serial #(
    parameter int BIT_SIZE = 20,
    parameter int DIGITS   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    bin_to_bcd_serial_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(BIT_SIZE + 1);
    localparam int BCD_W = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [BIT_SIZE-1:0] shreg, shreg_next;
    logic [BCD_W-1:0]    scratch, scratch_next;
    logic [BCD_W-1:0]    adj;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                ovf_pend, ovf_pend_next;
    logic [BCD_W-1:0]    bcd_q, bcd_next;
    logic                ovf_q, ovf_next;
    logic                busy_q, done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            scratch  <= scratch_next;
            cnt      <= cnt_next;
            ovf_pend <= ovf_pend_next;
            bcd_q    <= bcd_next;
            ovf_q    <= ovf_next;
            // Flags are registered from the next state so they line up with it exactly.
            busy_q   <= (state_next == SHIFT);
            done_q   <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        scratch_next  = scratch;
        cnt_next      = cnt;
        ovf_pend_next = ovf_pend;
        bcd_next      = bcd_q;
        ovf_next      = ovf_q;

        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_next    = bus.bin_in;
                    scratch_next  = '0;
                    cnt_next      = CNT_W'(BIT_SIZE);
                    ovf_pend_next = (64'(bus.bin_in) > MAX_VAL);
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // The top bit of the adjusted scratch falls off; overflow covers that case.
                scratch_next = {adj[BCD_W-2:0], shreg[BIT_SIZE-1]};
                shreg_next   = {shreg[BIT_SIZE-2:0], 1'b0};
                cnt_next     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                    bcd_next   = ovf_pend ? NINES : scratch_next;
                    ovf_next   = ovf_pend;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed and randomized checks of bin_to_bcd_serial against a decimal-arithmetic model.
`timescale 1ns/1ps
module tb_bin_to_bcd_serial;
  localparam int BIT_SIZE = 20;
  localparam int DIGITS   = 6;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  bin_to_bcd_serial_if #(.BIT_SIZE(BIT_SIZE), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_serial #(.BIT_SIZE(BIT_SIZE), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [24:0] exp_q[$];
  logic [23:0] last_bcd = '0;
  logic        last_ovf = 1'b0;

  // reference model: decimal digits by division, saturate above 999999
  function automatic logic [24:0] ref_model(input logic [19:0] v);
    int unsigned x;
    logic [23:0] b;
    x = v;
    b = '0;
    if (x > 999999) return {1'b1, 24'h999999};
    for (int d = 0; d < 6; d++) begin
      b[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one full conversion, checked cycle by cycle
  task automatic run_conv(input logic [19:0] v, input int glitch_at,
                          input bit hold_start, input bit poke_done);
    logic [24:0] exp;
    bus.start  = 1'b1;
    bus.bin_in = v;
    exp_q.push_back(ref_model(v));
    tick();
    if (!hold_start) bus.start = 1'b0;
    bus.bin_in = 20'($urandom);
    for (int i = 0; i < BIT_SIZE; i++) begin
      check("busy_shift", bus.busy, 1);
      check("done_early", bus.done, 0);
      if (i == 0 || i == BIT_SIZE - 1) begin
        check("hold_bcd", bus.bcd_out, last_bcd);
        check("hold_ovf", bus.overflow, last_ovf);
      end
      if (i == glitch_at) begin
        bus.start  = 1'b1;
        bus.bin_in = 20'($urandom);
      end else if (!hold_start) begin
        bus.start = 1'b0;
      end
      tick();
    end
    if (poke_done) bus.start = 1'b1;
    exp = exp_q.pop_front();
    check("done_pulse", bus.done, 1);
    check("busy_in_done", bus.busy, 0);
    check("bcd_out", bus.bcd_out, exp[23:0]);
    check("overflow", bus.overflow, exp[24]);
    last_bcd = exp[23:0];
    last_ovf = exp[24];
    tick();
    if (!hold_start) bus.start = 1'b0;
    check("done_after", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    check("idle_state", dbg_state, 0);
    check("bcd_kept", bus.bcd_out, last_bcd);
  endtask

  initial begin
    logic [19:0] v;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bcd", bus.bcd_out, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // directed cases
    run_conv(20'd0, -1, 1'b0, 1'b0);
    run_conv(20'd123456, -1, 1'b0, 1'b0);
    run_conv(20'd999999, -1, 1'b0, 1'b0);
    run_conv(20'd1048575, -1, 1'b0, 1'b0);
    run_conv(20'd500, 4, 1'b0, 1'b0);
    run_conv(20'd77, -1, 1'b0, 1'b1);

    // reset in the middle of a conversion
    bus.start  = 1'b1;
    bus.bin_in = 20'd654321;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_bcd", bus.bcd_out, 0);
    check("abort_ovf", bus.overflow, 0);
    check("abort_state", dbg_state, 0);
    last_bcd = '0;
    last_ovf = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      check("no_done_after_abort", bus.done, 0);
      tick();
    end
    run_conv(20'd42, -1, 1'b0, 1'b0);

    // back-to-back with start held high
    run_conv(20'd1, -1, 1'b1, 1'b0);
    run_conv(20'd2, -1, 1'b1, 1'b0);
    run_conv(20'd3, -1, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick();

    // randomized
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 20'($urandom_range(999990, 1000010));
        1:       v = 20'($urandom_range(0, 999));
        default: v = 20'($urandom);
      endcase
      run_conv(v, int'($urandom_range(0, 20)) - 1, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
